// File: rtl/calc_entry.sv
// Keypad number-entry stage: builds a signed 16-bit operand from decimal key
// events (digits, backspace, negate, clear) and drives the display data bytes.
module calc_entry (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [7:0] data_outH,
  output logic [7:0] data_outL,
  output logic       err
);

  typedef enum logic {IDLE = 1'b0, DIV = 1'b1} state_t;

  localparam logic [3:0]  KEY_BKSP  = 4'hA;
  localparam logic [3:0]  KEY_NEG   = 4'hB;
  localparam logic [3:0]  KEY_CLR   = 4'hC;
  localparam logic [18:0] MAG_MAX   = 19'd32767;
  localparam logic [3:0]  LAST_ITER = 4'd14;

  state_t             state, state_nx;
  logic [14:0]        mag, mag_nx;
  logic               neg, neg_nx;
  logic               err_nx;
  logic [3:0]         cnt, cnt_nx;
  logic [14:0]        dvd, dvd_nx;
  logic [3:0]         rem, rem_nx;
  logic [13:0]        quo, quo_nx;
  logic [18:0]        t;
  logic [4:0]         rem_sh;
  logic               q_bit;
  logic signed [15:0] value_nx;

  // Sign-apply the magnitude; -0 naturally collapses to 16'h0000.
  function automatic logic signed [15:0] to_value(input logic [14:0] m, input logic n);
    logic signed [15:0] sm;
    sm = signed'({1'b0, m});
    return n ? -sm : sm;
  endfunction

  // mag*10 + d as shift-add; 19 bits hold the worst case 32767*10+9.
  function automatic logic [18:0] mac10(input logic [14:0] m, input logic [3:0] d);
    return ({4'b0, m} << 3) + ({4'b0, m} << 1) + {15'b0, d};
  endfunction

  assign key_ready = (state == IDLE);
  assign t         = mac10(mag, key_code);
  assign rem_sh    = {rem, dvd[14]};
  assign q_bit     = (rem_sh >= 5'd10);
  assign value_nx  = to_value(mag_nx, neg_nx);

  always_comb begin
    state_nx = state;
    mag_nx   = mag;
    neg_nx   = neg;
    err_nx   = 1'b0;
    cnt_nx   = cnt;
    dvd_nx   = dvd;
    rem_nx   = rem;
    quo_nx   = quo;
    case (state)
      IDLE: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (t <= MAG_MAX) mag_nx = t[14:0];
            else              err_nx = 1'b1;
          end else begin
            case (key_code)
              KEY_BKSP: begin
                if (mag == 15'd0) begin
                  neg_nx = 1'b0;
                end else begin
                  dvd_nx   = mag;
                  rem_nx   = 4'd0;
                  cnt_nx   = 4'd0;
                  state_nx = DIV;
                end
              end
              KEY_NEG: neg_nx = ~neg;
              KEY_CLR: begin
                mag_nx = 15'd0;
                neg_nx = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      DIV: begin
        // One restoring-division step; the low 4 bits of rem_sh-10 are exact since the result is < 10.
        dvd_nx = {dvd[13:0], 1'b0};
        rem_nx = q_bit ? (rem_sh[3:0] - 4'd10) : rem_sh[3:0];
        quo_nx = {quo[12:0], q_bit};
        cnt_nx = cnt + 4'd1;
        if (cnt == LAST_ITER) begin
          mag_nx   = {quo, q_bit};
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control and output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mag       <= 15'd0;
      neg       <= 1'b0;
      cnt       <= 4'd0;
      err       <= 1'b0;
      data_outH <= 8'd0;
      data_outL <= 8'd0;
    end else begin
      state     <= state_nx;
      mag       <= mag_nx;
      neg       <= neg_nx;
      cnt       <= cnt_nx;
      err       <= err_nx;
      data_outH <= value_nx[15:8];
      data_outL <= value_nx[7:0];
    end
  end

  // Divider datapath; always reloaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    dvd <= dvd_nx;
    rem <= rem_nx;
    quo <= quo_nx;
  end

endmodule

// File: tb/tb_calc_entry.sv
// Scoreboard bench for calc_entry: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_calc_entry;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [7:0] data_outH;
  logic [7:0] data_outL;
  logic       err;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    logic        err;
    logic        rdy;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 0;
  bit   mon_done = 0;

  calc_entry dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .data_outH (data_outH),
    .data_outL (data_outL),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (e.cyc != cyc || {data_outH, data_outL} !== e.val || err !== e.err || key_ready !== e.rdy) begin
          errors++;
          $display("FAIL %s @cyc %0d: got val=%h err=%b rdy=%b, expected val=%h err=%b rdy=%b (tag %0d)",
                   e.name, cyc, {data_outH, data_outL}, err, key_ready, e.val, e.err, e.rdy, e.cyc);
        end
      end
      if (stim_done && !mon_done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        mon_done = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input logic [15:0] v, input logic e, input logic r, input string nm);
    exp_q.push_back('{c, v, e, r, nm});
  endtask

  task automatic press(input logic [3:0] code, input logic [15:0] v, input logic e, input string nm);
    key_valid = 1'b1;
    key_code  = code;
    expect_at(cyc + 1, v, e, 1'b1, nm);
    step();
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic [15:0] v, input string nm);
    for (int i = 0; i < n; i++) begin
      expect_at(cyc + 1, v, 1'b0, 1'b1, nm);
      step();
    end
  endtask

  // Non-zero backspace: 15 busy cycles holding old value, with junk keys offered throughout.
  task automatic bksp(input logic [15:0] old_v, input logic [15:0] new_v, input string nm);
    int ca;
    ca = cyc + 1;
    key_valid = 1'b1;
    key_code  = 4'hA;
    for (int i = 0; i < 15; i++) expect_at(ca + i, old_v, 1'b0, 1'b0, {nm, "_busy"});
    expect_at(ca + 15, new_v, 1'b0, 1'b1, {nm, "_done"});
    step();
    for (int i = 0; i < 15; i++) begin
      key_code = 4'(i);
      step();
    end
    key_valid = 1'b0;
  endtask

  initial begin
    int ca;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    expect_at(1, 16'h0000, 1'b0, 1'b1, "reset_hold");
    step(); step(); step();
    rst = 1'b0;
    idle(1, 16'h0000, "reset_state");

    // 1,2,3,4 back to back
    press(4'h1, 16'h0001, 1'b0, "d1");
    press(4'h2, 16'h000C, 1'b0, "d12");
    press(4'h3, 16'h007B, 1'b0, "d123");
    press(4'h4, 16'h04D2, 1'b0, "d1234");
    idle(2, 16'h04D2, "hold1234");

    // negate then multi-cycle backspace
    press(4'hB, 16'hFB2E, 1'b0, "neg1234");
    bksp(16'hFB2E, 16'hFF85, "bs_m1234");
    idle(1, 16'hFF85, "hold_m123");

    // overflow boundary
    press(4'hC, 16'h0000, 1'b0, "clr1");
    press(4'h3, 16'h0003, 1'b0, "e3");
    press(4'h2, 16'h0020, 1'b0, "e32");
    press(4'h7, 16'h0147, 1'b0, "e327");
    press(4'h6, 16'h0CCC, 1'b0, "e3276");
    press(4'h7, 16'h7FFF, 1'b0, "e32767");
    press(4'h0, 16'h7FFF, 1'b1, "ovf_d0");
    idle(1, 16'h7FFF, "ovf_err_drop");
    press(4'hC, 16'h0000, 1'b0, "clr2");
    press(4'h3, 16'h0003, 1'b0, "f3");
    press(4'h2, 16'h0020, 1'b0, "f32");
    press(4'h7, 16'h0147, 1'b0, "f327");
    press(4'h6, 16'h0CCC, 1'b0, "f3276");
    press(4'h8, 16'h0CCC, 1'b1, "ovf_d8");
    idle(1, 16'h0CCC, "ovf8_err_drop");

    // negative zero and sign retention
    press(4'hC, 16'h0000, 1'b0, "clr3");
    press(4'hB, 16'h0000, 1'b0, "neg_zero");
    press(4'h5, 16'hFFFB, 1'b0, "m5");
    bksp(16'hFFFB, 16'h0000, "bs_m5");
    press(4'h7, 16'hFFF9, 1'b0, "m7_retained");
    bksp(16'hFFF9, 16'h0000, "bs_m7");
    press(4'hA, 16'h0000, 1'b0, "bs_zero_single");
    press(4'h7, 16'h0007, 1'b0, "p7_neg_cleared");

    // ignored codes at idle
    press(4'hD, 16'h0007, 1'b0, "ign_D");
    press(4'hE, 16'h0007, 1'b0, "ign_E");
    press(4'hF, 16'h0007, 1'b0, "ign_F");
    idle(1, 16'h0007, "ign_hold");

    // clear from -500
    press(4'hC, 16'h0000, 1'b0, "clr4");
    press(4'h5, 16'h0005, 1'b0, "g5");
    press(4'h0, 16'h0032, 1'b0, "g50");
    press(4'h0, 16'h01F4, 1'b0, "g500");
    press(4'hB, 16'hFE0C, 1'b0, "gm500");
    press(4'hC, 16'h0000, 1'b0, "clr_m500");

    // reset in the 8th cycle of a division from 32767
    press(4'h3, 16'h0003, 1'b0, "h3");
    press(4'h2, 16'h0020, 1'b0, "h32");
    press(4'h7, 16'h0147, 1'b0, "h327");
    press(4'h6, 16'h0CCC, 1'b0, "h3276");
    press(4'h7, 16'h7FFF, 1'b0, "h32767");
    ca = cyc + 1;
    key_valid = 1'b1;
    key_code  = 4'hA;
    for (int i = 0; i < 8; i++) expect_at(ca + i, 16'h7FFF, 1'b0, 1'b0, "rstdiv_busy");
    expect_at(ca + 8, 16'h0000, 1'b0, 1'b1, "rstdiv_after");
    step();
    key_valid = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    press(4'h9, 16'h0009, 1'b0, "post_rst_d9");
    idle(2, 16'h0009, "final_hold");

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    stim_done = 1;
    for (int i = 0; i < 10 && !mon_done; i++) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
